// File: rtl/sig_delay_meas.sv
// sig_delay_meas: in-line loop-back latency meter for a sample delay path.
// Blanks the path until its output has been quiet, injects one marker
// sample and counts sample strobes until the marker is seen coming back.
module sig_delay_meas #(
  parameter int WIDTH     = 12,
  parameter int QUIET_LEN = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] tx_data,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             start,
  input  logic [WIDTH-2:0] threshold,
  input  logic [WIDTH-1:0] marker,
  input  logic [14:0]      timeout,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  output logic [14:0]      measured
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_QUIET = 3'd1,
    S_SEND  = 3'd2,
    S_WAIT  = 3'd3,
    S_FAIL  = 3'd4,
    S_END   = 3'd5
  } state_e;

  localparam logic [7:0]  QUIET_LEN_C = 8'(QUIET_LEN);
  localparam logic [14:0] CNT_MAX     = 15'h7FFF;

  // Magnitude of a signed sample; the most negative code saturates to the
  // largest positive magnitude so it still fits in WIDTH-1 bits.
  function automatic logic [WIDTH-2:0] sat_abs(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] neg;
    neg = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    if (!v[WIDTH-1]) begin
      sat_abs = v[WIDTH-2:0];
    end else if (v[WIDTH-2:0] == {(WIDTH-1){1'b0}}) begin
      sat_abs = {(WIDTH-1){1'b1}};
    end else begin
      sat_abs = neg[WIDTH-2:0];
    end
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  quiet_q, quiet_d;
  logic [14:0] phase_q, phase_d;
  logic [14:0] limit_q, limit_d;
  logic [14:0] measured_q, measured_d;
  logic        timed_out_q, timed_out_d;

  logic        detect;
  logic [7:0]  quiet_nx;
  logic [14:0] phase_inc;

  // Return-sample detector and counter increments shared by the FSM.
  always_comb begin
    detect    = (sat_abs(rx_data) >= threshold);
    phase_inc = phase_q + 15'd1;
    if (detect) begin
      quiet_nx = 8'd0;
    end else begin
      quiet_nx = quiet_q + 8'd1;
    end
  end

  // State register together with the measurement counters and results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      quiet_q     <= 8'd0;
      phase_q     <= 15'd0;
      limit_q     <= 15'd0;
      measured_q  <= 15'd0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      quiet_q     <= quiet_d;
      phase_q     <= phase_d;
      limit_q     <= limit_d;
      measured_q  <= measured_d;
      timed_out_q <= timed_out_d;
    end
  end

  // Next-state and counter update; only valid strobes advance anything.
  always_comb begin
    state_d     = state_q;
    quiet_d     = quiet_q;
    phase_d     = phase_q;
    limit_d     = limit_q;
    measured_d  = measured_q;
    timed_out_d = timed_out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          quiet_d     = 8'd0;
          phase_d     = 15'd0;
          timed_out_d = 1'b0;
          if (timeout == 15'd0) begin
            limit_d = CNT_MAX;
          end else begin
            limit_d = timeout;
          end
          state_d = S_QUIET;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_QUIET: begin
        if (data_valid) begin
          phase_d = phase_inc;
          quiet_d = quiet_nx;
          // Quiet completion wins over a timeout on the same strobe.
          if (quiet_nx == QUIET_LEN_C) begin
            state_d = S_SEND;
          end else if (phase_inc == limit_q) begin
            state_d = S_FAIL;
          end else begin
            state_d = S_QUIET;
          end
        end else begin
          state_d = S_QUIET;
        end
      end
      S_SEND: begin
        if (data_valid) begin
          phase_d = 15'd0;
          state_d = S_WAIT;
        end else begin
          state_d = S_SEND;
        end
      end
      S_WAIT: begin
        if (data_valid) begin
          phase_d = phase_inc;
          // A return on the last allowed strobe still counts as a hit.
          if (detect) begin
            measured_d  = phase_inc;
            timed_out_d = 1'b0;
            state_d     = S_END;
          end else if (phase_inc == limit_q) begin
            state_d = S_FAIL;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_FAIL: begin
        measured_d  = CNT_MAX;
        timed_out_d = 1'b1;
        state_d     = S_END;
      end
      S_END: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the state register: path mux and status flags.
  always_comb begin
    tx_data = data_in;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_data = data_in;
      end
      S_QUIET, S_WAIT, S_FAIL: begin
        tx_data = {WIDTH{1'b0}};
        busy    = 1'b1;
      end
      S_SEND: begin
        tx_data = marker;
        busy    = 1'b1;
      end
      S_END: begin
        tx_data = {WIDTH{1'b0}};
        done    = 1'b1;
      end
      default: begin
        tx_data = data_in;
      end
    endcase
  end

  assign timed_out = timed_out_q;
  assign measured  = measured_q;

endmodule

// File: tb/tb_sig_delay_meas.sv
// Bench for sig_delay_meas: loops tx_data through a strobe-based delay path
// model and predicts each result from the recorded return samples.
module tb_sig_delay_meas;

  localparam int W    = 12;
  localparam int QLEN = 16;
  localparam int HALF = 1 << (W - 1);

  logic         clk = 1'b0;
  logic         rst_n;
  logic         data_valid;
  logic [W-1:0] data_in;
  logic [W-1:0] tx_data;
  logic [W-1:0] rx_data;
  logic         start;
  logic [W-2:0] threshold;
  logic [W-1:0] marker;
  logic [14:0]  timeout;
  logic         busy;
  logic         done;
  logic         timed_out;
  logic [14:0]  measured;

  sig_delay_meas #(.WIDTH(W), .QUIET_LEN(QLEN)) dut (
    .clk(clk), .rst_n(rst_n), .data_valid(data_valid), .data_in(data_in),
    .tx_data(tx_data), .rx_data(rx_data), .start(start), .threshold(threshold),
    .marker(marker), .timeout(timeout), .busy(busy), .done(done),
    .timed_out(timed_out), .measured(measured)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Bench state: path model, stimulus knobs and per-measurement recordings.
  int path_q[$];
  int rx_mode;            // 0: delay path, 1: stuck value (with optional noise)
  int stuck_val, noise_idx, noise_val;
  int thr, mrk, vper;
  bit recording;
  int rx_rec[$], tx_rec[$], cyc_rec[$];
  int cyc, last_tx, last_din, prev_meas;

  task automatic check_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic bit det(input int raw);
    int s, a;
    s = (raw >= HALF) ? raw - 2 * HALF : raw;
    a = (s < 0) ? -s : s;
    if (a > HALF - 1) a = HALF - 1;
    return a >= thr;
  endfunction

  function automatic bit vfn();
    if (vper > 0) return (cyc % vper) == 0;
    return $urandom_range(0, 99) < 60;
  endfunction

  task automatic set_path(input int n);
    path_q.delete();
    for (int i = 0; i < n; i++) path_q.push_back($urandom_range(0, 2 * HALF - 1));
  endtask

  // One clock: drive inputs, sample tx_data, feed the path, cross the edge.
  task automatic drive_cycle(input bit v, input bit st);
    int rx_v;
    data_valid = v;
    start      = st;
    data_in    = W'($urandom_range(0, 2 * HALF - 1));
    if (!v) rx_v = $urandom_range(0, 2 * HALF - 1);
    else if (rx_mode == 0) rx_v = path_q[0];
    else if (recording && (rx_rec.size() + 1 == noise_idx)) rx_v = noise_val;
    else rx_v = stuck_val;
    rx_data = rx_v[W-1:0];
    #1;
    last_tx  = int'(tx_data);
    last_din = int'(data_in);
    if (v) begin
      if (recording) begin
        rx_rec.push_back(rx_v);
        tx_rec.push_back(last_tx);
        cyc_rec.push_back(cyc);
      end
      path_q.push_back(last_tx);
      void'(path_q.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Expected outcome from the recorded return samples (1-based strobe indices
  // counted from the first strobe after start).
  task automatic predict(input int limit, output int e_meas, output int e_to,
                         output int e_mark, output int e_dec);
    int qend, n;
    bit quiet_ok;
    qend = 0; n = rx_rec.size();
    e_meas = -1; e_to = -1; e_mark = 0; e_dec = -1;
    for (int k = QLEN; k <= limit && k <= n && qend == 0; k++) begin
      quiet_ok = 1'b1;
      for (int i = k - QLEN; i < k; i++) if (det(rx_rec[i])) quiet_ok = 1'b0;
      if (quiet_ok) qend = k;
    end
    if (qend == 0) begin
      if (limit <= n) begin
        e_meas = 32767; e_to = 1; e_dec = limit;
      end
      return;
    end
    e_mark = qend + 1;
    for (int j = 1; j <= limit && e_mark + j <= n; j++) begin
      if (det(rx_rec[e_mark + j - 1])) begin
        e_meas = j; e_to = 0; e_dec = e_mark + j;
        break;
      end
      if (j == limit) begin
        e_meas = 32767; e_to = 1; e_dec = e_mark + j;
      end
    end
  endtask

  task automatic run_meas(input string tag, input int tmo, input bit xstart,
                          input int exp_const);
    int limit, done_cyc, meas_bad, e_meas, e_to, e_mark, e_dec, bad, exp_tx;
    limit     = (tmo == 0) ? 32767 : tmo;
    threshold = thr[W-2:0];
    marker    = mrk[W-1:0];
    timeout   = tmo[14:0];
    drive_cycle(vfn(), 1'b0);
    drive_cycle(vfn(), 1'b0);
    check_val({tag, "_idle_tx"}, last_tx, last_din);
    rx_rec.delete(); tx_rec.delete(); cyc_rec.delete();
    drive_cycle(vfn(), 1'b1);
    recording = 1'b1;
    check_val({tag, "_busy"}, int'(busy), 1);
    done_cyc = -1; meas_bad = 0;
    for (int c = 0; c < 9000; c++) begin
      timeout = 15'($urandom);
      drive_cycle(vfn(), xstart && (c % 7 == 3));
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (int'(measured) != prev_meas) meas_bad++;
    end
    recording = 1'b0;
    check_val({tag, "_done_seen"}, int'(done_cyc >= 0), 1);
    if (done_cyc < 0) begin
      rst_n = 1'b0; #3; rst_n = 1'b1;
      prev_meas = 0;
      return;
    end
    check_val({tag, "_hold"}, meas_bad, 0);
    predict(limit, e_meas, e_to, e_mark, e_dec);
    check_val({tag, "_measured"}, int'(measured), e_meas);
    check_val({tag, "_timed_out"}, int'(timed_out), e_to);
    if (exp_const >= 0) check_val({tag, "_plan"}, int'(measured), exp_const);
    if (e_dec > 0) begin
      bad = 0;
      for (int i = 1; i <= e_dec; i++) begin
        exp_tx = (i == e_mark) ? mrk : 0;
        if (tx_rec[i-1] != exp_tx) bad++;
      end
      check_val({tag, "_tx"}, bad, 0);
      check_val({tag, "_latency"}, done_cyc - cyc_rec[e_dec-1], (e_to == 1) ? 2 : 1);
    end
    // start raised while done is high must be ignored
    drive_cycle(vfn(), 1'b1);
    check_val({tag, "_end_busy"}, int'(busy), 0);
    check_val({tag, "_end_done"}, int'(done), 0);
    check_val({tag, "_end_hold"}, int'(measured), e_meas);
    prev_meas = e_meas;
  endtask

  initial begin
    int found, cnt;
    rst_n = 1'b0; data_valid = 1'b0; start = 1'b0; data_in = 12'h5A5;
    rx_data = 12'h000; threshold = 11'd100; marker = 12'd2000; timeout = 15'd0;
    cyc = 0; prev_meas = 0; recording = 1'b0; rx_mode = 0; vper = 1;
    noise_idx = -1; noise_val = 0; stuck_val = 0; thr = 100; mrk = 2000;
    set_path(1);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_timed_out", int'(timed_out), 0);
    check_val("rst_measured", int'(measured), 0);
    check_val("rst_tx", int'(tx_data), 12'h5A5);
    rst_n = 1'b1;

    // One-strobe register loop.
    set_path(1); rx_mode = 0; vper = 1; thr = 100; mrk = 2000;
    run_meas("loop1", 0, 1'b0, 1);
    // Long path with sparse strobes and ignored extra starts, then short path.
    set_path(503); vper = 3;
    run_meas("dly503", 0, 1'b1, 503);
    set_path(3);
    run_meas("dly3", 0, 1'b1, 3);
    // Dead return path: marker never comes back.
    rx_mode = 1; stuck_val = 0; vper = 1;
    run_meas("stuck0", 50, 1'b0, 32767);
    // Most negative sample keeps the detector asserted: quiet never completes.
    stuck_val = 2048;
    run_meas("neg_sat", 40, 1'b0, 32767);
    // A single noisy return sample restarts the quiet window.
    stuck_val = 0; noise_idx = 10; noise_val = 500;
    run_meas("noise", 60, 1'b0, 32767);
    check_val("noise_send26", (tx_rec.size() > 26) ? tx_rec[26] : -1, mrk);
    noise_idx = -1;

    // Asynchronous reset while waiting for the marker.
    rx_mode = 0; set_path(30); vper = 1; thr = 100; mrk = 1500;
    threshold = 11'd100; marker = 12'd1500; timeout = 15'd0;
    drive_cycle(1'b1, 1'b0);
    drive_cycle(1'b1, 1'b1);
    found = 0;
    for (int c = 0; c < 600 && found == 0; c++) begin
      drive_cycle(1'b1, 1'b0);
      if (last_tx == mrk) found = 1;
    end
    check_val("rst_marker_seen", found, 1);
    repeat (5) drive_cycle(1'b1, 1'b0);
    check_val("rst_busy_before", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_busy", int'(busy), 0);
    check_val("arst_done", int'(done), 0);
    check_val("arst_timed_out", int'(timed_out), 0);
    check_val("arst_measured", int'(measured), 0);
    check_val("arst_tx", int'(tx_data), int'(data_in));
    @(posedge clk);
    #3 rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      drive_cycle(1'b1, 1'b0);
      cnt += int'(done);
    end
    check_val("arst_no_done", cnt, 0);
    check_val("arst_idle", int'(busy), 0);
    prev_meas = 0;

    // Randomized paths, thresholds, markers, strobe densities and limits.
    for (int r = 0; r < 8; r++) begin
      set_path($urandom_range(1, 40));
      vper = $urandom_range(0, 3);
      thr  = $urandom_range(1, HALF - 1);
      mrk  = $urandom_range(0, 2 * HALF - 1);
      run_meas("rnd", $urandom_range(20, 300), 1'($urandom_range(0, 1)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sig_delay_meas.md
Name: sig_delay_meas

Overview:
- Measures the sample latency of a delay path, such as the runtime-configurable delay line, by looping through it.
- Sits in-line in front of the delay path: forwards input samples to the path, injects one marker sample, then counts sample strobes until the marker returns on the path output.
- Used for calibrating and self-testing the programmed delay over the register interface.

Parameters:
WIDTH, 12, sample width in bits; samples are signed two's complement
QUIET_LEN, 16, consecutive below-threshold return samples required before the marker is sent (1..255)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
data_valid  in  1  sample strobe, one per sample
data_in  in  WIDTH  normal sample stream
tx_data  out  WIDTH  samples toward the delay path
rx_data  in  WIDTH  samples returned from the delay path, qualified by data_valid
start  in  1  single-cycle request to begin a measurement
threshold  in  WIDTH-1  unsigned detection magnitude
marker  in  WIDTH  marker sample value
timeout  in  15  maximum strobes per phase; 0 means 32767
busy  out  1  high while a measurement is in progress
done  out  1  one-cycle pulse when a measurement ends
timed_out  out  1  result flag, valid from done
measured  out  15  measured latency in strobes, valid from done

Behaviour:
- Clock is clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, busy=0, done=0, timed_out=0, measured=0, internal counters 0.
- Reset asserted mid-measurement aborts immediately. No done pulse is produced.
- Detect is |rx_data| >= threshold.
  - The absolute value saturates: the most negative value maps to 2^(WIDTH-1)-1.
  - Detect is only evaluated on cycles where data_valid=1.
- tx_data is combinational from the state register and data_in:
  - IDLE: tx_data = data_in.
  - QUIET and WAIT: tx_data = 0, blanking the path.
  - SEND: tx_data = marker.
- FSM transitions are evaluated on clk edges:
  - IDLE:
    - If start=1, clear the quiet counter, the phase counter and timed_out, then go to QUIET with busy=1.
    - start is ignored in every other state.
  - QUIET: on each valid strobe, phase counter +1.
    - If detect, the quiet counter is cleared.
    - If not detect, the quiet counter +1.
    - When the quiet counter reaches QUIET_LEN, go to SEND.
    - Otherwise, if the phase counter reaches the timeout limit, go to FAIL.
  - SEND: wait for the next valid strobe, on which the marker is emitted.
    - On that strobe, clear the phase counter and go to WAIT.
    - Detect is not evaluated in SEND.
  - WAIT: on each valid strobe, cnt_next = cnt+1.
    - If detect, set measured=cnt_next and timed_out=0, then go to END.
    - Otherwise, if cnt_next equals the limit, go to FAIL.
    - Detect takes priority over timeout on the same strobe.
  - FAIL: set measured=15'h7FFF and timed_out=1, then go to END.
  - END: done=1 for exactly one clk, busy=0, then go to IDLE.
    - measured and timed_out hold until the next start.
- The timeout limit is the value of the timeout port, or 32767 when the port is 0.
  - The limit is sampled at start; later changes have no effect on the running measurement.
  - threshold and marker are used live.
- Latency definition: measured = number of valid strobes after the marker strobe, up to and including the strobe on which detect occurs.
  - A path that returns tx_data one strobe later yields 1.
  - The counter cannot wrap because the limit is 32767 or less.
- Gaps in data_valid do not advance any counter.
- A start pulse in the same cycle as END is ignored.
- The host re-issues start after done.

Test Plan:
- Loop through a 1-strobe register, threshold=100, marker=2000, data_valid every cycle, start -> after 16 quiet strobes plus SEND: done with measured=1, timed_out=0.
- Loop through the delay line with delay=500 (path latency 503 strobes), data_valid every 3rd cycle -> measured=503. Repeat with delay=0 -> measured=3.
- Return path stuck at 0, timeout=50 -> done exactly 50 strobes after the marker, measured=0x7FFF, timed_out=1.
- rx_data stuck at -2048 (WIDTH=12), threshold=100, timeout=40 -> the saturating abs detects, QUIET never completes, FAIL after 40 strobes. The FAIL path never emits the marker.
- Inject one noise sample above threshold at quiet strobe 10 -> the quiet counter restarts, and SEND occurs at strobe 26.
- rst_n low in WAIT -> outputs return to their reset values asynchronously with no done pulse, and tx_data returns to data_in. A second start while busy is ignored, and measured is unchanged.
